ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//  Parametrised time-multiplexed seven-segment display driver for NUM_DIGITS hex digits.
//  It decodes hex and scans the digits with a programmable refresh rate.
//  It also provides PWM brightness, leading-zero blanking, decimal points, a guard
//  (dead) cycle against ghosting, and tear-free double-buffered loading.
//  It sits between the value-formatting logic (BCD/hex digits) and the board anode/cathode pins.
// PARAMETERS
//  NUM_DIGITS   4      digits scanned, >=2
//  REFRESH_DIV  100000 clock cycles per digit slot; must be >= 2**DUTY_BITS
//  DUTY_BITS    3      width of brightness_i
// PORTS
//  clock         in   1              system clock, rising edge
//  reset         in   1              asynchronous, active-low
//  digits_i      in   4*NUM_DIGITS   hex nibbles; digit k = [4k+3:4k], digit 0 = rightmost
//  dp_i          in   NUM_DIGITS     decimal point per digit, 1 = lit
//  load_i        in   1              1-cycle strobe: capture digits_i/dp_i into the pending buffer
//  blank_lead_i  in   1              1 = blank leading zero digits
//  brightness_i  in   DUTY_BITS      0 = dimmest, all-ones = full
//  anode_o       out  NUM_DIGITS     digit enables, active-low, one-hot-low
//  cathode_o     out  7              segments {g,f,e,d,c,b,a}, active-low
//  dp_o          out  1              decimal point, active-low
//  frame_o       out  1              1-cycle pulse when slot wraps to digit 0
// BEHAVIOUR
//  Reset (async, reset==0): all outputs inactive and held there.
//   - anode_o all 1s; cathode_o 7'h7F; dp_o 1; frame_o 0.
//   - Prescaler 0, slot 0, active and pending buffers 0, pending flag 0.
//   - Reset mid-operation aborts the scan immediately, with no partial frame.
//  Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt==REFRESH_DIV-1).
//  Slot: slot advances on tick and wraps NUM_DIGITS-1 -> 0. Scan order is 0,1,..,N-1.
//  Frame boundary: tick while slot==NUM_DIGITS-1.
//   - frame_o is asserted on the cycle the new slot 0 appears on the outputs.
//  Double buffer:
//   - load_i writes the pending buffer and sets the pending flag.
//   - At a frame boundary with the pending flag set, pending is copied to active and the flag clears.
//   - load_i on the boundary cycle: the boundary copy uses the previous pending contents.
//     The new data stays pending, with the flag set, until the next boundary.
//   - Back-to-back loads: the last load wins. The display never shows a mixed frame.
//  PWM:
//   - on_cycles = ((brightness_i+1)*REFRESH_DIV) >> DUTY_BITS.
//   - The digit is enabled when 0 < cnt <= on_cycles, clipped to REFRESH_DIV-1.
//   - cnt==0 is always the guard cycle: all anodes off.
//   - brightness_i is sampled continuously. A change takes effect within the current slot.
//  Blanking:
//   - With blank_lead_i=1, a digit k>0 is blanked when it and all digits above it are 0.
//   - Digit 0 is never blanked.
//   - A blanked digit has cathode_o=7'h7F, but its dp_o still follows dp_i.
//  Output: any disabled cycle drives anode_o all 1s, cathode_o 7'h7F and dp_o 1.
//  Latency: all outputs are registered, 1 cycle after the cnt/slot state that selects them.
//  Widths:
//   - cnt is $clog2(REFRESH_DIV) bits; slot is $clog2(NUM_DIGITS) bits.
//   - on_cycles is computed at DUTY_BITS+$clog2(REFRESH_DIV)+1 bits, so it cannot overflow.
// STRUCTURE
//  Package ssd_pkg:
//   - 16-entry active-low segment table SEG_HEX[0:15] (0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12 ...).
//   - SEG_BLANK = 7'h7F.
//  Sub-module ssd_hex_decoder: combinational nibble -> 7-bit active-low pattern.
//  Top level: prescaler, slot counter, double buffer, blanking mask, PWM compare, output registers.
// TESTING  (bench: NUM_DIGITS=4, REFRESH_DIV=8, DUTY_BITS=3)
//  1. Scan: brightness 7, load 16'h1234, dp_i 0.
//     -> anode 1110 with cathode 7'h19, then 1101/7'h30, 1011/7'h24, 0111/7'h79.
//     -> 7 lit cycles per slot; frame_o every 32 cycles.
//  2. Blank: blank_lead_i=1, load 16'h0050.
//     -> slots 3 and 2 show 7'h7F; slot 1 shows 7'h12; slot 0 shows 7'h40.
//     -> load 16'h0000: only slot 0 lit (7'h40).
//  3. PWM: brightness 0 -> each digit lit only at cnt==1; brightness 3 -> lit at cnt 1..4.
//     cnt==0 is never lit.
//  4. Tear-free: load 16'hABCD mid-frame while 16'h1234 is active.
//     -> remaining slots still show 1234; next frame shows ABCD.
//     -> load on the boundary cycle itself is shown one frame later.
//  5. Reset mid-slot: drop reset asynchronously.
//     -> anode 4'hF and cathode 7'h7F immediately (no clock edge).
//     -> after release, display is blank (value 0, digit 0 shows 7'h40) until a load.
//  6. dp_i=4'b0100, blank_lead=1, value 16'h0000.
//     -> slot 2: cathode 7'h7F, dp_o 0; slot 0: cathode 7'h40, dp_o 1.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared segment encodings for the seven-segment scan driver
package ssd_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // active-low {g,f,e,d,c,b,a} patterns for 0..F
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction
endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: combinational hex nibble to active-low segment pattern
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_seg(nibble);
endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed hex display scanner with PWM, blanking and double buffering
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DUTY_BITS   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_lead_i,
  input  logic [DUTY_BITS-1:0]    brightness_i,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [6:0]              cathode_o,
  output logic                    dp_o,
  output logic                    frame_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int OW = DUTY_BITS + CW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(NUM_DIGITS - 1);
  localparam logic [OW-1:0] ON_MAX = OW'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] DIG0 = NUM_DIGITS'(1);
  logic [CW-1:0] cnt;
  logic [SW-1:0] slot;
  logic [4*NUM_DIGITS-1:0] pend_dig, act_dig;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp, lead_zero, blank;
  logic pend_vld, wrapped, tick, boundary, en;
  logic [OW-1:0] on_cycles, on_lim;
  logic [3:0] nibble;
  logic [6:0] seg;
  assign tick = cnt == CNT_MAX;
  assign boundary = tick && slot == SLOT_MAX;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt     <= '0;
      slot    <= '0;
      wrapped <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + 1'b1;
      if (tick) slot <= slot == SLOT_MAX ? '0 : slot + 1'b1;
      wrapped <= boundary;
    end
  // a load on the boundary cycle stays pending; the copy takes the older contents
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      act_dig  <= '0;
      act_dp   <= '0;
    end else begin
      if (load_i) begin
        pend_dig <= digits_i;
        pend_dp  <= dp_i;
      end
      if (boundary && pend_vld) begin
        act_dig <= pend_dig;
        act_dp  <= pend_dp;
      end
      pend_vld <= load_i || (pend_vld && !boundary);
    end
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = act_dig[4*NUM_DIGITS-1 -: 4] == 4'h0;
    for (int k = NUM_DIGITS - 2; k >= 0; k--)
      lead_zero[k] = lead_zero[k+1] && act_dig[4*k +: 4] == 4'h0;
    blank = blank_lead_i ? {lead_zero[NUM_DIGITS-1:1], 1'b0} : '0;
  end
  assign on_cycles = ((OW'(brightness_i) + OW'(1)) * OW'(REFRESH_DIV)) >> DUTY_BITS;
  assign on_lim = on_cycles > ON_MAX ? ON_MAX : on_cycles;
  assign en = cnt != '0 && OW'(cnt) <= on_lim;
  assign nibble = act_dig[{slot, 2'b00} +: 4];
  ssd_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (seg)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      anode_o   <= '1;
      cathode_o <= SEG_BLANK;
      dp_o      <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      anode_o   <= en ? ~(DIG0 << slot) : '1;
      cathode_o <= en && !blank[slot] ? seg : SEG_BLANK;
      dp_o      <= !(en && act_dp[slot]);
      frame_o   <= wrapped;
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed checks of scan, blanking, PWM, buffering and reset
module tb_ssd_scan_driver;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        blank_lead_i;
  logic [2:0]  brightness_i;
  logic [3:0]  anode_o;
  logic [6:0]  cathode_o;
  logic        dp_o;
  logic        frame_o;
  int errors = 0;
  int checks = 0;
  logic [3:0] an [32];
  logic [6:0] ca [32];
  logic       dpo [32];
  logic       fr [32];

  ssd_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DUTY_BITS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .digits_i     (digits_i),
    .dp_i         (dp_i),
    .load_i       (load_i),
    .blank_lead_i (blank_lead_i),
    .brightness_i (brightness_i),
    .anode_o      (anode_o),
    .cathode_o    (cathode_o),
    .dp_o         (dp_o),
    .frame_o      (frame_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load();
    load_i = 1'b1;
    @(negedge clock);
    load_i = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_o && n < 80);
    chk(tag, frame_o, 1);
  endtask

  task automatic capture();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clock);
      an[i] = anode_o;
      ca[i] = cathode_o;
      dpo[i] = dp_o;
      fr[i] = frame_o;
    end
  endtask

  function automatic int lit_in(input int base);
    int c = 0;
    for (int i = 0; i < 8; i++) if (an[base+i] != 4'hF) c++;
    return c;
  endfunction

  function automatic int frames_after_first();
    int c = 0;
    for (int i = 1; i < 32; i++) if (fr[i]) c++;
    return c;
  endfunction

  initial begin
    reset = 1'b1;
    load_i = 1'b0;
    digits_i = '0;
    dp_i = '0;
    blank_lead_i = 1'b0;
    brightness_i = 3'd7;
    #1 reset = 1'b0;
    #2;
    chk("rst_anode", anode_o, 4'hF);
    chk("rst_cathode", cathode_o, 7'h7F);
    chk("rst_dp", dp_o, 1);
    chk("rst_frame", frame_o, 0);
    @(negedge clock);
    #2 reset = 1'b1;
    // scan order and segment codes
    digits_i = 16'h1234;
    do_load();
    wait_frame("t1_frame");
    capture();
    chk("t1_guard_an", an[0], 4'hF);
    chk("t1_guard_ca", ca[0], 7'h7F);
    chk("t1_s0_an", an[1], 4'b1110);
    chk("t1_s0_ca", ca[1], 7'h19);
    chk("t1_s1_an", an[9], 4'b1101);
    chk("t1_s1_ca", ca[9], 7'h30);
    chk("t1_s2_an", an[17], 4'b1011);
    chk("t1_s2_ca", ca[17], 7'h24);
    chk("t1_s3_an", an[25], 4'b0111);
    chk("t1_s3_ca", ca[25], 7'h79);
    chk("t1_lit_s0", lit_in(0), 7);
    chk("t1_lit_s3", lit_in(24), 7);
    chk("t1_guard_s1", an[8], 4'hF);
    chk("t1_frame_once", frames_after_first(), 0);
    @(negedge clock);
    chk("t1_period", frame_o, 1);
    // leading-zero blanking
    blank_lead_i = 1'b1;
    digits_i = 16'h0050;
    do_load();
    wait_frame("t2_frame");
    capture();
    chk("t2_s3_ca", ca[25], 7'h7F);
    chk("t2_s3_an", an[25], 4'b0111);
    chk("t2_s2_ca", ca[17], 7'h7F);
    chk("t2_s1_ca", ca[9], 7'h12);
    chk("t2_s0_ca", ca[1], 7'h40);
    @(negedge clock);
    digits_i = 16'h0000;
    do_load();
    wait_frame("t2b_frame");
    capture();
    chk("t2b_s0_ca", ca[1], 7'h40);
    chk("t2b_s1_ca", ca[9], 7'h7F);
    chk("t2b_s2_ca", ca[17], 7'h7F);
    chk("t2b_s3_ca", ca[25], 7'h7F);
    // PWM duty
    blank_lead_i = 1'b0;
    brightness_i = 3'd0;
    wait_frame("t3_frame");
    capture();
    chk("t3_b0_guard", an[0], 4'hF);
    chk("t3_b0_on", an[1], 4'b1110);
    chk("t3_b0_off", an[2], 4'hF);
    chk("t3_b0_lit", lit_in(0), 1);
    chk("t3_b0_lit_s2", lit_in(16), 1);
    chk("t3_b0_ca", ca[1], 7'h40);
    brightness_i = 3'd3;
    wait_frame("t3b_frame");
    capture();
    chk("t3_b3_last_on", an[4], 4'b1110);
    chk("t3_b3_first_off", an[5], 4'hF);
    chk("t3_b3_lit_s1", lit_in(8), 4);
    chk("t3_b3_guard_s1", an[8], 4'hF);
    // tear-free load mid-frame
    brightness_i = 3'd7;
    digits_i = 16'h1234;
    do_load();
    wait_frame("t4_frame");
    repeat (12) @(negedge clock);
    digits_i = 16'hABCD;
    do_load();
    repeat (4) @(negedge clock);
    chk("t4_old_s2_an", anode_o, 4'b1011);
    chk("t4_old_s2_ca", cathode_o, 7'h24);
    repeat (8) @(negedge clock);
    chk("t4_old_s3_ca", cathode_o, 7'h79);
    wait_frame("t4_new_frame");
    capture();
    chk("t4_new_s0", ca[1], 7'h21);
    chk("t4_new_s1", ca[9], 7'h46);
    chk("t4_new_s2", ca[17], 7'h03);
    chk("t4_new_s3", ca[25], 7'h08);
    // load on the boundary cycle, with an earlier load already pending
    @(negedge clock);
    repeat (12) @(negedge clock);
    digits_i = 16'h5678;
    do_load();
    repeat (17) @(negedge clock);
    digits_i = 16'h1234;
    do_load();
    @(negedge clock);
    chk("t4b_frame", frame_o, 1);
    capture();
    chk("t4b_prev_s0", ca[1], 7'h00);
    chk("t4b_prev_s3", ca[25], 7'h12);
    wait_frame("t4c_frame");
    capture();
    chk("t4c_s0", ca[1], 7'h19);
    chk("t4c_s3", ca[25], 7'h79);
    // asynchronous reset mid-slot
    @(negedge clock);
    repeat (3) @(negedge clock);
    chk("t5_pre_an", anode_o, 4'b1110);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_an", anode_o, 4'hF);
    chk("t5_async_ca", cathode_o, 7'h7F);
    chk("t5_async_dp", dp_o, 1);
    chk("t5_async_frame", frame_o, 0);
    @(negedge clock);
    chk("t5_hold_an", anode_o, 4'hF);
    #2 reset = 1'b1;
    wait_frame("t5_frame");
    capture();
    chk("t5_s0_ca", ca[1], 7'h40);
    chk("t5_s0_an", an[1], 4'b1110);
    chk("t5_s1_ca", ca[9], 7'h40);
    chk("t5_s3_ca", ca[25], 7'h40);
    chk("t5_s3_an", an[25], 4'b0111);
    // decimal point on a blanked digit
    dp_i = 4'b0100;
    blank_lead_i = 1'b1;
    digits_i = 16'h0000;
    do_load();
    wait_frame("t6_frame");
    capture();
    chk("t6_s2_an", an[17], 4'b1011);
    chk("t6_s2_ca", ca[17], 7'h7F);
    chk("t6_s2_dp", dpo[17], 0);
    chk("t6_s2_guard_dp", dpo[16], 1);
    chk("t6_s1_ca", ca[9], 7'h7F);
    chk("t6_s1_dp", dpo[9], 1);
    chk("t6_s0_ca", ca[1], 7'h40);
    chk("t6_s0_dp", dpo[1], 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
